// File: rtl/sum_accum.sv
// Frame accumulator: sums N unsigned operands per frame with saturation,
// then holds the total behind a valid/ready output until it is taken.
module sum_accum #(
  parameter int SUM_W = 5,
  parameter int N     = 8,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sum_valid,
  input  logic [SUM_W-1:0] sum,
  output logic             sum_ready,
  output logic             acc_valid,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_ovf,
  input  logic             acc_ready
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic               armed;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic               in_hs, out_hs, last;
  logic [ACC_W:0]     sum_ext, acc_sum;

  assign sum_ext = {{(ACC_W + 1 - SUM_W){1'b0}}, sum};
  assign acc_sum = {1'b0, acc} + sum_ext;

  // armed keeps the input closed until the first edge after reset release
  assign sum_ready = armed && (state == ACCUM) && !clear;
  assign acc_valid = (state == DONE);
  assign acc_data  = acc;
  assign acc_ovf   = ovf;
  assign in_hs     = sum_valid && sum_ready;
  assign out_hs    = acc_valid && acc_ready;
  assign last      = (cnt == CNT_W'(N - 1));

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (in_hs && last) state_nxt = DONE;
        DONE:    if (acc_ready)     state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Once saturated, the total stays pinned at all-ones until the frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (clear || out_hs) begin
        cnt <= '0;
        acc <= '0;
        ovf <= 1'b0;
      end else if (in_hs) begin
        cnt <= cnt + 1'b1;
        if (acc_sum[ACC_W] || ovf) begin
          acc <= '1;
          ovf <= 1'b1;
        end else begin
          acc <= acc_sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule
